// File: rtl/tt_mux_pkg.sv
// Shared types and word layout for the muxed project array host controller.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_RESET = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int IW_W       = 18;
    localparam int OW_W       = 24;
    localparam int IW_CLK     = 0;
    localparam int IW_RST_N   = 1;
    localparam int OW_UO_OUT  = 0;
    localparam int OW_UIO_OUT = 8;
    localparam int OW_UIO_OE  = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_mux_ow_sel.sv
// Registered NUM_PROJ:1 mux of wrapper output words; forces zero when not valid.
// Latency 1 cycle from ow_bus; no backpressure.
module tt_mux_ow_sel
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OW_W*NUM_PROJ-1:0] ow_bus,
    input  logic [3:0]               sel,
    input  logic                     valid,
    output logic [OW_W-1:0]          ow_host
);

    logic [OW_W-1:0] slice;

    always_comb begin
        slice = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (sel == 4'(k)) slice = ow_bus[k*OW_W +: OW_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ow_host <= '0;
        else        ow_host <= valid ? slice : '0;
    end

endmodule

// File: rtl/tt_mux_ctrl.sv
// Host controller: accepts project selects, sequences gap/reset/run on one-hot ena.
// Select-to-run GAP_CYCLES+RST_CYCLES+1 cycles; iw/ow_host 1 cycle; sel_ready low while switching.
module tt_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int NUM_PROJ   = 4,
    parameter int GAP_CYCLES = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               sel_addr,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    output logic                     sel_err,
    output logic                     busy,
    input  logic [IW_W-1:0]          iw_host,
    output logic [NUM_PROJ-1:0]      ena,
    output logic [IW_W-1:0]          iw,
    input  logic [OW_W*NUM_PROJ-1:0] ow_bus,
    output logic [OW_W-1:0]          ow_host,
    output logic                     ow_valid
);

    localparam int CW = $clog2(max2(GAP_CYCLES, RST_CYCLES) + 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [3:0]          sel_idx;
    logic                sel_vld;
    logic                accept;
    logic                addr_ok;
    logic [NUM_PROJ-1:0] ena_nxt;

    assign sel_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign busy      = (state == ST_GAP) || (state == ST_RESET);
    assign accept    = sel_valid && sel_ready;
    assign addr_ok   = ({1'b0, sel_addr} < 5'(NUM_PROJ));

    always_comb begin
        ena_nxt = '0;
        for (int k = 0; k < NUM_PROJ; k++) begin
            if (sel_vld && sel_idx == 4'(k)) ena_nxt[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sel_idx <= '0;
            sel_vld <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (accept) begin
                        if (addr_ok) begin
                            state   <= ST_GAP;
                            cnt     <= CW'(GAP_CYCLES);
                            sel_idx <= sel_addr;
                            sel_vld <= 1'b1;
                        end else begin
                            state   <= ST_IDLE;
                            sel_vld <= 1'b0;
                            sel_err <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt <= CW'(1)) begin
                        state <= ST_RESET;
                        cnt   <= CW'(RST_CYCLES);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESET: begin
                    if (cnt <= CW'(1)) state <= ST_RUN;
                    else               cnt   <= cnt - CW'(1);
                end
            endcase
        end
    end

    // Outputs follow the state register by one edge, so the old enable drops
    // on the edge after the accept and the new one rises GAP_CYCLES later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena      <= '0;
            iw       <= '0;
            ow_valid <= 1'b0;
        end else begin
            ow_valid <= (state == ST_RUN);
            case (state)
                ST_RESET: begin
                    ena <= ena_nxt;
                    iw  <= iw_host & ~(IW_W'(1) << IW_RST_N);
                end
                ST_RUN: begin
                    ena <= ena_nxt;
                    iw  <= iw_host;
                end
                default: begin
                    ena <= '0;
                    iw  <= '0;
                end
            endcase
        end
    end

    tt_mux_ow_sel #(.NUM_PROJ(NUM_PROJ)) u_ow_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .ow_bus  (ow_bus),
        .sel     (sel_idx),
        .valid   (state == ST_RUN),
        .ow_host (ow_host)
    );

endmodule
